// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and decode helper,
// used by the timing generator and the draw modules.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // True when lo <= v < hi (half-open window, unsigned).
  function automatic logic in_window(input int unsigned v,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N up counter with a wrap flag asserted in the enabled cycle
// where the count rolls over from MODULUS-1 to 0.
module wrap_counter #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned MODULUS = 800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  generate
    if ((MODULUS < 1) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_mod_chk
      $error("wrap_counter: MODULUS must be in 1..2**WIDTH");
    end
  endgenerate

  // Rollover is flagged combinationally so the next stage steps in the same edge.
  assign wrap = en && (count == LAST);

  // Count up while enabled, return to zero after the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      if (wrap) count <= '0;
      else      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: two cascaded wrap counters produce the raster
// position; all outputs are registered from the counters on pix_en.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned BIT      = 10,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_en,
  output logic [BIT-1:0] x_pos,
  output logic [BIT-1:0] y_pos,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic           line_start,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  generate
    if (64'(H_TOTAL) > (64'd1 << BIT)) begin : g_h_chk
      $error("vga_timing_gen: H_TOTAL exceeds 2**BIT");
    end
    if (64'(V_TOTAL) > (64'd1 << BIT)) begin : g_v_chk
      $error("vga_timing_gen: V_TOTAL exceeds 2**BIT");
    end
  endgenerate

  logic [BIT-1:0] h_cnt;
  logic [BIT-1:0] v_cnt;
  logic           h_wrap;
  logic           v_wrap;

  wrap_counter #(.WIDTH(BIT), .MODULUS(H_TOTAL)) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  wrap_counter #(.WIDTH(BIT), .MODULUS(V_TOTAL)) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  // A frame can only end on a line boundary.
  a_frame_on_line: assert property (@(posedge clk) disable iff (!rst_n) v_wrap |-> h_wrap);

  // The counters run one position ahead of the outputs: each pix_en edge
  // presents the current count and decodes it, so the first enabled cycle
  // after reset shows 0,0 and every output shares the same register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos       <= '0;
      y_pos       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      x_pos       <= h_cnt;
      y_pos       <= v_cnt;
      hsync       <= !in_window(32'(h_cnt), HS_START, HS_END);
      vsync       <= !in_window(32'(v_cnt), VS_START, VS_END);
      display_on  <= in_window(32'(h_cnt), 0, H_ACTIVE) && in_window(32'(v_cnt), 0, V_ACTIVE);
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing, plus a
// tiny-raster instance (15x8) so a whole frame fits in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic pe;
  logic pe_s;

  logic [9:0] x, y;
  logic hs, vs, de, ls, fs;
  logic [3:0] xs, ys;
  logic hs_s, vs_s, de_s, ls_s, fs_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pe),
    .x_pos(x), .y_pos(y), .hsync(hs), .vsync(vs),
    .display_on(de), .line_start(ls), .frame_start(fs)
  );

  // Small raster: H 8/2/3/2 = 15, V 4/1/2/1 = 8.
  // hsync low for x 10..12, vsync low for y 5..6, display x<8 && y<4.
  vga_timing_gen #(
    .BIT(4),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pe_s),
    .x_pos(xs), .y_pos(ys), .hsync(hs_s), .vsync(vs_s),
    .display_on(de_s), .line_start(ls_s), .frame_start(fs_s)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    pe = 1'b1;
    pe_s = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (x !== 10'd0)  begin failures++; $display("FAIL reset_x got=%0d exp=0", x); end
    checks++; if (y !== 10'd0)  begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
    checks++; if (hs !== 1'b1)  begin failures++; $display("FAIL reset_hsync got=%b exp=1", hs); end
    checks++; if (vs !== 1'b1)  begin failures++; $display("FAIL reset_vsync got=%b exp=1", vs); end
    checks++; if (de !== 1'b0)  begin failures++; $display("FAIL reset_display got=%b exp=0", de); end
    checks++; if (ls !== 1'b0)  begin failures++; $display("FAIL reset_line_start got=%b exp=0", ls); end
    checks++; if (fs !== 1'b0)  begin failures++; $display("FAIL reset_frame_start got=%b exp=0", fs); end
    checks++; if (xs !== 4'd0 || fs_s !== 1'b0)
      begin failures++; $display("FAIL reset_small got x=%0d fs=%b exp x=0 fs=0", xs, fs_s); end
    pe_s = 1'b0;
  endtask

  task automatic test_first_cycle();
    rst_n = 1'b1;
    pe = 1'b1;
    @(negedge clk);
    checks++; if (x !== 10'd0 || y !== 10'd0)
      begin failures++; $display("FAIL first_pos got=%0d,%0d exp=0,0", x, y); end
    checks++; if (de !== 1'b1) begin failures++; $display("FAIL first_display got=%b exp=1", de); end
    checks++; if (ls !== 1'b1) begin failures++; $display("FAIL first_line_start got=%b exp=1", ls); end
    checks++; if (fs !== 1'b1) begin failures++; $display("FAIL first_frame_start got=%b exp=1", fs); end
  endtask

  task automatic test_line();
    int pos_err = 0;
    int hs_low = 0;
    int hs_first = -1;
    int de_cnt = 0;
    int ls_cnt = 0;
    int fs_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (x !== 10'(i) || y !== 10'd0) pos_err++;
      if (hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      if (de === 1'b1) de_cnt++;
      if (ls === 1'b1) ls_cnt++;
      if (fs === 1'b1) fs_cnt++;
      @(negedge clk);
    end
    checks++; if (pos_err != 0)  begin failures++; $display("FAIL line_x_seq got=%0d bad positions exp=0", pos_err); end
    checks++; if (hs_low != 96)  begin failures++; $display("FAIL line_hsync_len got=%0d exp=96", hs_low); end
    checks++; if (hs_first != 656) begin failures++; $display("FAIL line_hsync_start got=%0d exp=656", hs_first); end
    checks++; if (de_cnt != 640) begin failures++; $display("FAIL line_display_len got=%0d exp=640", de_cnt); end
    checks++; if (ls_cnt != 1)   begin failures++; $display("FAIL line_start_count got=%0d exp=1", ls_cnt); end
    checks++; if (fs_cnt != 1)   begin failures++; $display("FAIL line_frame_count got=%0d exp=1", fs_cnt); end
    checks++; if (x !== 10'd0 || y !== 10'd1)
      begin failures++; $display("FAIL line_wrap got=%0d,%0d exp=0,1", x, y); end
    checks++; if (ls !== 1'b1 || fs !== 1'b0)
      begin failures++; $display("FAIL line2_pulses got ls=%b fs=%b exp ls=1 fs=0", ls, fs); end
  endtask

  task automatic test_pix_en_toggle();
    for (int k = 0; k < 4; k++) begin
      pe = 1'b0;
      @(negedge clk);
      checks++; if (x !== 10'(k) || ls !== 1'b0 || fs !== 1'b0)
        begin failures++; $display("FAIL toggle_idle k=%0d got x=%0d ls=%b fs=%b exp x=%0d ls=0 fs=0", k, x, ls, fs, k); end
      pe = 1'b1;
      @(negedge clk);
      checks++; if (x !== 10'(k + 1) || y !== 10'd1)
        begin failures++; $display("FAIL toggle_step k=%0d got %0d,%0d exp %0d,1", k, x, y, k + 1); end
    end
  endtask

  task automatic test_async_reset();
    pe = 1'b1;
    repeat (296) @(negedge clk);
    checks++; if (x !== 10'd300 || y !== 10'd1 || de !== 1'b1)
      begin failures++; $display("FAIL pre_reset_pos got %0d,%0d de=%b exp 300,1 de=1", x, y, de); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (x !== 10'd0 || y !== 10'd0 || hs !== 1'b1 || vs !== 1'b1 || de !== 1'b0 || ls !== 1'b0 || fs !== 1'b0)
      begin failures++; $display("FAIL async_reset got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b exp 0 0 1 1 0 0 0",
                                 x, y, hs, vs, de, ls, fs); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (x !== 10'd0 || y !== 10'd0 || fs !== 1'b1 || de !== 1'b1)
      begin failures++; $display("FAIL post_reset got %0d,%0d fs=%b de=%b exp 0,0 fs=1 de=1", x, y, fs, de); end
    @(negedge clk);
    checks++; if (x !== 10'd1 || fs !== 1'b0)
      begin failures++; $display("FAIL post_reset_step got x=%0d fs=%b exp x=1 fs=0", x, fs); end
  endtask

  task automatic test_small_frame();
    int pos_err = 0;
    int dec_err = 0;
    int vs_low = 0;
    int vs_first_y = -1;
    int fs_cnt = 0;
    int ex, ey;
    logic ehs, evs, ede;
    pe_s = 1'b1;
    for (int i = 0; i <= 120; i++) begin
      @(negedge clk);
      ex = i % 15;
      ey = (i / 15) % 8;
      ehs = !(ex >= 10 && ex < 13);
      evs = !(ey >= 5 && ey < 7);
      ede = (ex < 8) && (ey < 4);
      if (xs !== 4'(ex) || ys !== 4'(ey)) pos_err++;
      if (hs_s !== ehs || vs_s !== evs || de_s !== ede || ls_s !== (ex == 0)) dec_err++;
      if (i < 120) begin
        if (vs_s === 1'b0) begin
          vs_low++;
          if (vs_first_y < 0) vs_first_y = int'(ys);
        end
        if (fs_s === 1'b1) fs_cnt++;
      end
      if (i == 0) begin
        checks++; if (fs_s !== 1'b1) begin failures++; $display("FAIL small_fs_first got=%b exp=1", fs_s); end
      end
      if (i == 119) begin
        checks++; if (xs !== 4'd14 || ys !== 4'd7)
          begin failures++; $display("FAIL corner_pos got %0d,%0d exp 14,7", xs, ys); end
      end
      if (i == 120) begin
        checks++; if (xs !== 4'd0 || ys !== 4'd0 || fs_s !== 1'b1 || hs_s !== 1'b1 || vs_s !== 1'b1)
          begin failures++; $display("FAIL corner_wrap got %0d,%0d fs=%b hs=%b vs=%b exp 0,0 1 1 1",
                                     xs, ys, fs_s, hs_s, vs_s); end
      end
    end
    checks++; if (pos_err != 0)  begin failures++; $display("FAIL small_pos_seq got=%0d bad exp=0", pos_err); end
    checks++; if (dec_err != 0)  begin failures++; $display("FAIL small_decode got=%0d bad exp=0", dec_err); end
    checks++; if (vs_low != 30)  begin failures++; $display("FAIL small_vsync_len got=%0d exp=30", vs_low); end
    checks++; if (vs_first_y != 5) begin failures++; $display("FAIL small_vsync_line got=%0d exp=5", vs_first_y); end
    checks++; if (fs_cnt != 1)   begin failures++; $display("FAIL small_fs_count got=%0d exp=1", fs_cnt); end
  endtask

  task automatic test_hold();
    pe_s = 1'b1;
    @(negedge clk);
    pe_s = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (xs !== 4'd1 || ys !== 4'd0 || ls_s !== 1'b0 || fs_s !== 1'b0 || de_s !== 1'b1)
      begin failures++; $display("FAIL hold got x=%0d y=%0d ls=%b fs=%b de=%b exp 1 0 0 0 1",
                                 xs, ys, ls_s, fs_s, de_s); end
  endtask

  initial begin
    rst_n = 1'b0;
    pe = 1'b0;
    pe_s = 1'b0;
    test_reset();
    test_first_cycle();
    test_line();
    test_pix_en_toggle();
    test_async_reset();
    test_small_frame();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter BIT, default 10, is the width of the coordinate outputs.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, give the horizontal timing in pixels.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, give the vertical timing in lines.
REQ-004 clk  input  1  single pixel-domain clock; all logic is on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pix_en  input  1  pixel-advance enable; counters move only in cycles where it is high.
REQ-007 x_pos  output  BIT  current horizontal count, 0..H_TOTAL-1.
REQ-008 y_pos  output  BIT  current vertical count, 0..V_TOTAL-1.
REQ-009 hsync  output  1  horizontal sync, active low.
REQ-010 vsync  output  1  vertical sync, active low.
REQ-011 display_on  output  1  high when x_pos<H_ACTIVE and y_pos<V_ACTIVE.
REQ-012 line_start  output  1  one-cycle pulse, valid when the position is x_pos==0.
REQ-013 frame_start  output  1  one-cycle pulse, valid when the position is x_pos==0 and y_pos==0.

Function
REQ-014 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800), and V_TOTAL SHALL equal the sum of the vertical terms (525).
REQ-015 When pix_en=1, x_pos SHALL increment by 1, wrapping from H_TOTAL-1 to 0.
REQ-016 y_pos SHALL increment only in the cycle where x_pos wraps, wrapping from V_TOTAL-1 to 0.
REQ-017 When pix_en=0, every output SHALL hold its value, and line_start/frame_start SHALL be 0.
REQ-018 hsync SHALL be 0 exactly for H_ACTIVE+H_FP <= x_pos < H_ACTIVE+H_FP+H_SYNC (656..751), and 1 otherwise.
REQ-019 vsync SHALL be 0 exactly for V_ACTIVE+V_FP <= y_pos < V_ACTIVE+V_FP+V_SYNC (490..491), and 1 otherwise.
REQ-020 hsync, vsync and display_on SHALL be registered and SHALL correspond to the x_pos/y_pos presented in the same cycle, with zero skew between outputs.
REQ-021 line_start SHALL be high for exactly one pix_en-qualified cycle per line.
REQ-022 frame_start SHALL be high for exactly one pix_en-qualified cycle per frame.
REQ-023 Counter arithmetic SHALL be unsigned at BIT width, with no out-of-range value ever presented.
REQ-024 An elaboration check SHALL fail if H_TOTAL or V_TOTAL exceeds 2**BIT.
REQ-025 The block SHALL contain no combinational path from pix_en to any output.

Reset
REQ-026 While rst_n=0, x_pos=0, y_pos=0, hsync=1, vsync=1 and display_on=0.
REQ-027 While rst_n=0, line_start=0 and frame_start=0.
REQ-028 Assertion of rst_n mid-frame SHALL clear the state immediately, independent of clk.
REQ-029 After release of rst_n, the first pix_en cycle SHALL present x=0, y=0 with display_on=1, line_start=1 and frame_start=1.

Structure
REQ-030 The default timing constants and the derived H_TOTAL/V_TOTAL SHALL live in shared package vga_pkg, also used by the draw modules.
REQ-031 One sub-module, wrap_counter, SHALL be instantiated twice: horizontal (enable=pix_en) and vertical (enable=horizontal wrap).
REQ-032 wrap_counter SHALL be parameterised by width and modulus, and SHALL output its count and a wrap flag.

Verification
REQ-033 Reset, then pix_en=1 continuously for 800 cycles -> x_pos runs 0..799 then 0; y_pos steps 0->1 at the wrap.
REQ-034 Over one full line -> hsync is low for exactly 96 cycles starting at x=656; display_on is high for 640 cycles.
REQ-035 Run 420000 cycles -> vsync is low for exactly 1600 cycles at y=490..491; frame_start pulses once, at cycle 0 and again at cycle 420000.
REQ-036 pix_en toggling 1,0,1,0 -> x advances every second cycle, and no pulse appears while pix_en=0.
REQ-037 rst_n asserted at x=300, y=200 -> outputs reach reset values asynchronously; after release, counting resumes from 0,0.
REQ-038 Corner position x=799, y=524, pix_en=1 -> next state x=0, y=0, with frame_start=1, hsync=1 and vsync=1.
